// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - oversampled UART receive deserializer with parity/frame checks
//   baud_clk     oversampling clock, all logic on posedge
//   reset_n      async active-low reset
//   data_tx      serial line (async, idle high)
//   data_ready   consumer accepts data_out this cycle
//   data_out     received word
//   data_valid   data_out/flags valid, held until accepted
//   parity_err   parity mismatch for the word in data_out
//   frame_err    a stop bit sampled low for the word in data_out
//   overrun_err  1-cycle pulse: frame completed while holding reg full
//   active_flag  high while a frame is being received
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 baud_clk,
  input  logic                 reset_n,
  input  logic                 data_tx,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 active_flag
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_HM1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_H    = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_HP1  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD   = 1'(PARITY_ODD);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_m, rx_s;
  logic [TW-1:0]        tick, tick_nxt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 smp_a, smp_b, bit_val;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;

  logic maj, at_mid, at_end;
  logic start_frame, bit_rst, shift_en, perr_chk, ferr_chk, stop_adv, complete;

  // Two samples are stored; the third is the live rx_s at tick H+1.
  assign maj    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign at_mid = (tick == T_HP1);
  assign at_end = (tick == T_LAST);

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= data_tx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      tick  <= '0;
    end else begin
      state <= state_nxt;
      tick  <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tick_nxt    = tick + TW'(1);
    start_frame = 1'b0;
    bit_rst     = 1'b0;
    shift_en    = 1'b0;
    perr_chk    = 1'b0;
    ferr_chk    = 1'b0;
    stop_adv    = 1'b0;
    complete    = 1'b0;
    case (state)
      S_IDLE: begin
        tick_nxt = '0;
        if (!rx_s) begin
          // The detecting cycle counts as tick 0 of the start bit.
          state_nxt   = S_START;
          tick_nxt    = TW'(1);
          start_frame = 1'b1;
        end
      end
      S_START: begin
        if (at_mid && maj) begin
          state_nxt = S_IDLE;
          tick_nxt  = '0;
        end else if (at_end) begin
          state_nxt = S_DATA;
          bit_rst   = 1'b1;
        end
      end
      S_DATA: begin
        if (at_end) begin
          shift_en = 1'b1;
          if (bit_cnt == B_LAST) begin
            state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        perr_chk = at_mid;
        if (at_end) begin
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (at_mid) begin
          ferr_chk = 1'b1;
          // Leaving at mid-bit of the final stop re-arms early enough
          // to catch a start bit that follows with no idle gap.
          if (stop_cnt == STOP_LAST) begin
            complete  = 1'b1;
            state_nxt = S_IDLE;
            tick_nxt  = '0;
          end
        end else if (at_end) begin
          stop_adv = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tick_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_a    <= 1'b1;
      smp_b    <= 1'b1;
      bit_val  <= 1'b1;
      shreg    <= '1;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (tick == T_HM1) smp_a <= rx_s;
      if (tick == T_H)   smp_b <= rx_s;
      if (at_mid)        bit_val <= maj;
      if (start_frame) begin
        perr     <= 1'b0;
        ferr     <= 1'b0;
        stop_cnt <= 1'b0;
        bit_cnt  <= '0;
      end
      if (bit_rst) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (perr_chk) perr <= ((^shreg) ^ PAR_ODD) != maj;
      if (ferr_chk && !maj) ferr <= 1'b1;
      if (stop_adv) stop_cnt <= 1'b1;
    end
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      active_flag <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      active_flag <= (state_nxt != S_IDLE);
      if (complete) begin
        if (!data_valid || data_ready) begin
          data_out   <= shreg;
          parity_err <= perr;
          // Final stop bit is folded in directly; its ferr update lands too late.
          frame_err  <= ferr | ~maj;
          data_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - self-checking bench for uart_rx_deserializer
module tb_uart_rx_deserializer;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       data_tx;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, overrun_err, active_flag;

  always #5 clk = ~clk;

  uart_rx_deserializer dut (
    .baud_clk    (clk),
    .reset_n     (reset_n),
    .data_tx     (data_tx),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .active_flag (active_flag)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ovr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    data_tx = v;
    cyc(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int gap, input int gbit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        data_tx = d[i];
        cyc(OS / 2 - 1);
        data_tx = ~d[i];
        cyc(1);
        data_tx = d[i];
        cyc(OS / 2);
      end else begin
        send_bit(d[i]);
      end
    end
    send_bit(par);
    send_bit(stop);
    data_tx = 1'b1;
    cyc(gap);
  endtask

  // Every accepted word must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset_n) begin
      if (overrun_err) ovr_cnt++;
      if (data_valid && data_ready) begin
        check("word_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("data_out", 32'(data_out), 32'(e.d));
          check("parity_err", 32'(parity_err), 32'(e.pe));
          check("frame_err", 32'(frame_err), 32'(e.fe));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};

    reset_n    = 1'b0;
    data_tx    = 1'b1;
    data_ready = 1'b1;
    cyc(3);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_data_valid", 32'(data_valid), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun_err", 32'(overrun_err), 0);
    check("rst_active_flag", 32'(active_flag), 0);
    reset_n = 1'b1;
    cyc(5);

    // Directed table
    foreach (vecs[i]) begin
      q.push_back('{vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe});
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, vecs[i].stop ? 3 : 20, -1);
      check("table_frame_done", 32'(q.size()), 0);
    end

    // False start: 5-cycle low pulse
    data_tx = 1'b0;
    cyc(4);
    check("false_start_active", 32'(active_flag), 1);
    cyc(1);
    data_tx = 1'b1;
    cyc(11);
    check("false_start_idle", 32'(active_flag), 0);
    cyc(20);

    // Glitch at mid-bit of data bit 2
    q.push_back('{8'hF0, 1'b0, 1'b0});
    send_frame(8'hF0, 1'b0, 1'b1, 5, 2);
    check("glitch_frame_done", 32'(q.size()), 0);

    // Overrun: holding register full when the second frame completes
    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 4, -1);
    send_frame(8'h22, 1'b0, 1'b1, 20, -1);
    check("ovr_valid_held", 32'(data_valid), 1);
    check("ovr_data_kept", 32'(data_out), 32'h11);
    check("ovr_pulse_count", 32'(ovr_cnt), 1);
    q.push_back('{8'h11, 1'b0, 1'b0});
    data_ready = 1'b1;
    cyc(1);
    check("ovr_valid_falls", 32'(data_valid), 0);
    check("ovr_accepted", 32'(q.size()), 0);
    cyc(5);

    // Reset in the middle of the data bits
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_active", 32'(active_flag), 0);
    check("midrst_valid", 32'(data_valid), 0);
    data_tx = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    cyc(5);
    q.push_back('{8'h99, 1'b0, 1'b0});
    send_frame(8'h99, 1'b0, 1'b1, 5, -1);
    check("post_rst_frame_done", 32'(q.size()), 0);

    // Random frames against a rule-level model
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       par, stop;
      int         gap;
      d    = 8'($urandom);
      par  = 1'($urandom);
      stop = ($urandom % 5) != 0;
      gap  = stop ? int'($urandom_range(0, 10)) : 20;
      q.push_back('{d, par != (^d), ~stop});
      send_frame(d, par, stop, gap, -1);
      check("rand_frame_done", 32'(q.size()), 0);
    end

    cyc(20);
    check("final_queue_empty", 32'(q.size()), 0);
    check("final_overrun_total", 32'(ovr_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
